data_bus_arbiter: RTL
=====================

// Module: data_bus_arbiter
// PURPOSE
//  Two-master arbiter for the single data bus (memory port B, timer, GPIO address space).
//  Master 0 is the CPU data port; master 1 is a DMA/UART-side requester.
//  Round-robin with a burst cap. Registered request issue; fixed-latency reads
//  returned to the owning master through an owner-tag pipeline.
//  Sits between the masters and the address decoder/read-data mux.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  RD_LATENCY  1   clk cycles from s_valid to s_rdata valid (1..4)
//  MAX_BURST   4   max consecutive grants to one master while the other requests (1..15)
// PORTS
//  clk        in   1       system clock (CPU clock domain)
//  reset      in   1       asynchronous reset, active-high
//  m_req      in   2       per-master request; held with addr/we/wdata until granted
//  m_we       in   2       per-master write enable (1=write, 0=read)
//  m_addr0    in   ADDR_W  master 0 address
//  m_addr1    in   ADDR_W  master 1 address
//  m_wdata0   in   DATA_W  master 0 write data
//  m_wdata1   in   DATA_W  master 1 write data
//  m_lock     in   2       per-master bus lock (only with BUS_LOCK_EN)
//  m_gnt      out  2       one-cycle accept pulse, one-hot or zero
//  m_rvalid   out  2       one-cycle read-data-valid pulse to the owning master
//  m_rdata    out  DATA_W  read data (shared; qualified by m_rvalid)
//  s_valid    out  1       bus transfer issued this cycle
//  s_we       out  1       bus write strobe (valid with s_valid)
//  s_addr     out  ADDR_W  bus address
//  s_wdata    out  DATA_W  bus write data
//  s_rdata    in   DATA_W  bus read data from the decoder mux
// BEHAVIOUR
//  - Reset: every output 0; rr_ptr=0 (master 0 preferred); burst_cnt=0; owner pipe cleared.
//  - Arbitration is combinational on m_req. m_gnt is asserted in cycle t; s_* are
//    registered and driven in t+1 with s_valid=1. One grant per cycle; back-to-back allowed.
//  - Priority: the master selected by rr_ptr wins a conflict. Once a master is granted,
//    rr_ptr stays on it until either its request drops or burst_cnt reaches MAX_BURST
//    while the other master is requesting. rr_ptr then moves to the other master and
//    burst_cnt is cleared.
//  - burst_cnt increments per grant to the same master and saturates at MAX_BURST.
//    Any grant to the other master reloads it to 1.
//  - Single requester: granted every cycle, with no cap (the cap only applies under contention).
//  - Writes complete in the s_valid cycle; no response.
//  - Reads: the owner tag {valid,id} is shifted through a RD_LATENCY-deep pipe.
//    m_rvalid[id]=1 and m_rdata=s_rdata when the tag exits, RD_LATENCY cycles after
//    s_valid. Reads are fully pipelined and responses return in issue order.
//  - s_addr/s_we/s_wdata hold their last values when s_valid=0. m_rdata=0 when no rvalid.
//  - Simultaneous m_req=2'b11 on the first cycle after reset: master 0 is granted.
//  - Reset mid-read: the in-flight tags are discarded and no m_rvalid is produced.
// CONFIGURATION
//  BUS_LOCK_EN defined: while the current owner holds m_lock high, it keeps priority
//    regardless of MAX_BURST and the other master is not granted. Lock is ignored
//    when the owner's m_req is 0. Lock taken by master i only after a grant to i.
//  BUS_LOCK_EN undefined: m_lock is ignored (port present, unconnected); pure round-robin+cap.
// STRUCTURE
//  - Shared package bus_pkg: master ID type (1 bit), MST_CPU=0, MST_AUX=1, ADDR_W/DATA_W
//    defaults, RD_LATENCY max constant.
//  - Sub-module rd_tag_pipe: RD_LATENCY-deep {valid,id} shift register with async clear.
//    Arbiter FSM (rr_ptr, burst_cnt, lock state) stays in data_bus_arbiter.
// TESTING
//  1. Reset asserted mid-run -> all outputs 0 immediately; after release, m_req=01 ->
//     m_gnt=01 next edge, s_valid=1 in t+1.
//  2. M0 read addr 0x100, RD_LATENCY=1, s_rdata=0xDEADBEEF -> m_rvalid=01 and
//     m_rdata=0xDEADBEEF exactly 1 cycle after s_valid.
//  3. Both masters request continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...
//  4. M1 only, 10 writes -> 10 consecutive m_gnt=10 and s_we=1 pulses, with no gaps.
//  5. Interleaved reads M0/M1, RD_LATENCY=3 -> m_rvalid follows issue order, 3 cycles
//     after each s_valid; reset during flight -> no m_rvalid.
//  6. BUS_LOCK_EN: M0 m_lock=1 with both requesting for 8 cycles -> 8 M0 grants, then
//     lock drops -> M1 granted next.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared types and constants for the two-master data bus
//               arbiter: master identifiers, default bus widths, the deepest
//               supported read latency and the read owner-tag type.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // One bit is enough to name either master.
  typedef logic mst_id_t;

  localparam mst_id_t MST_CPU = 1'b0;  // CPU data port
  localparam mst_id_t MST_AUX = 1'b1;  // DMA / UART-side requester

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int RD_LATENCY_MAX = 4;

  // Read owner tag carried alongside an in-flight read.
  typedef struct packed {
    logic    vld;
    mst_id_t id;
  } rd_tag_t;

  function automatic mst_id_t other_mst(input mst_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_tag_pipe
// Description : RD_LATENCY-deep shift register of read owner tags {vld,id}.
//               A tag entered in the cycle a read is issued on the bus leaves
//               the pipe exactly RD_LATENCY cycles later, which is when the
//               decoder mux presents the matching read data.
// Ports       : clk    - system clock
//               reset  - asynchronous active-high clear (drops in-flight tags)
//               i_tag  - tag for the transfer issued this cycle
//               o_tag  - tag whose read data is on the bus this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
  import bus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe[0] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pipe[gi] <= '0;
        end else begin
          r_pipe[gi] <= r_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign o_tag = r_pipe[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Two-master round-robin arbiter with a burst cap for the
//               shared data bus. Grant is combinational on m_req; the
//               winning request is registered onto s_* one cycle later.
//               Read data is steered back to its owner via rd_tag_pipe.
// Ports       : clk, reset            - clock, async active-high reset
//               m_req/m_we/m_lock     - per-master request, write, lock
//               m_addr0/1, m_wdata0/1 - per-master address / write data
//               m_gnt                 - one-hot accept pulse (or zero)
//               m_rvalid, m_rdata     - read response to the owning master
//               s_valid/s_we/s_addr/s_wdata - registered bus transfer
//               s_rdata               - read data from the decoder mux
// Config      : BUS_LOCK_EN - when defined, a granted master holding m_lock
//               keeps the bus; otherwise m_lock is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  input  logic [DATA_W-1:0] m_wdata0,
  input  logic [DATA_W-1:0] m_wdata1,
  input  logic [1:0]        m_lock,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s_valid,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_BURST);

  // Round-robin pointer: which master wins a conflict.
  localparam logic [0:0] ST_PREF_CPU = 1'b0;
  localparam logic [0:0] ST_PREF_AUX = 1'b1;

  logic [0:0]        r_pref;
  logic [CNT_W-1:0]  r_burst;

  logic              w_gnt_vld;
  mst_id_t           w_gid;
  mst_id_t           w_other;
  logic              w_lock_hold;
  logic              w_lock_take;
  logic [CNT_W-1:0]  w_burst_inc;
  logic [CNT_W-1:0]  w_burst_nxt;
  logic              w_cap_hit;

  logic              r_s_valid;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  mst_id_t           r_s_id;

  rd_tag_t           w_tag_in;
  rd_tag_t           w_tag_out;

  // --------------------------------------------------------------------------
  // Bus lock
  // --------------------------------------------------------------------------
`ifdef BUS_LOCK_EN
  logic    r_lock_vld;
  mst_id_t r_lock_id;

  // Lock only counts for a master that was granted last cycle and is still
  // requesting with m_lock high.
  assign w_lock_hold = r_lock_vld && m_lock[r_lock_id] && m_req[r_lock_id];
  assign w_lock_take = w_gnt_vld && m_lock[w_gid];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= MST_CPU;
    end else begin
      r_lock_vld <= w_lock_take;
      r_lock_id  <= w_gid;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^m_lock;
  assign w_lock_hold   = 1'b0;
  assign w_lock_take   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gid     = MST_CPU;
    if (w_lock_hold) begin
`ifdef BUS_LOCK_EN
      w_gnt_vld = 1'b1;
      w_gid     = r_lock_id;
`endif
    end else if (&m_req) begin
      w_gnt_vld = 1'b1;
      // A saturated count here means the preferred master ran alone up to
      // the cap and the other one has just arrived: hand over immediately.
      if (r_burst == c_MAX) begin
        w_gid = other_mst(r_pref);
      end else begin
        w_gid = r_pref;
      end
    end else if (m_req[MST_CPU]) begin
      w_gnt_vld = 1'b1;
      w_gid     = MST_CPU;
    end else if (m_req[MST_AUX]) begin
      w_gnt_vld = 1'b1;
      w_gid     = MST_AUX;
    end
  end

  assign w_other = other_mst(w_gid);

  assign m_gnt = {w_gid, ~w_gid} & {2{w_gnt_vld & ~reset}};

  // --------------------------------------------------------------------------
  // Round-robin pointer and burst counter
  // --------------------------------------------------------------------------
  assign w_burst_inc = (r_burst == c_MAX) ? r_burst : r_burst + 1'b1;
  assign w_burst_nxt = (w_gid == r_pref) ? w_burst_inc : CNT_W'(1);
  assign w_cap_hit   = (w_burst_nxt == c_MAX) && m_req[w_other] && !w_lock_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pref  <= ST_PREF_CPU;
      r_burst <= '0;
    end else if (w_gnt_vld) begin
      if (w_cap_hit) begin
        r_pref  <= (w_other == MST_AUX) ? ST_PREF_AUX : ST_PREF_CPU;
        r_burst <= '0;
      end else begin
        r_pref  <= (w_gid == MST_AUX) ? ST_PREF_AUX : ST_PREF_CPU;
        r_burst <= w_burst_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered bus issue; address/data hold when idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_valid <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_id    <= MST_CPU;
    end else begin
      r_s_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s_we    <= m_we[w_gid];
        r_s_addr  <= (w_gid == MST_AUX) ? m_addr1  : m_addr0;
        r_s_wdata <= (w_gid == MST_AUX) ? m_wdata1 : m_wdata0;
        r_s_id    <= w_gid;
      end
    end
  end

  assign s_valid = r_s_valid;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;

  // --------------------------------------------------------------------------
  // Read response routing
  // --------------------------------------------------------------------------
  assign w_tag_in = {r_s_valid & ~r_s_we, r_s_id};

  rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign m_rvalid = {w_tag_out.id, ~w_tag_out.id} & {2{w_tag_out.vld}};
  assign m_rdata  = w_tag_out.vld ? s_rdata : '0;

endmodule
`default_nettype wire
